ps2_tx: RTL and testbench

PS/2 host-to-device transmitter: sends one byte from the host to the keyboard, e.g. LED-set command 0xED plus argument, or reset 0xFF. It is the opposite direction of the existing `kb` receiver and shares the PS2_CLK/PS2_DAT pins with it. It runs on clock_25. It drives both lines open-drain through output enables and reports completion, acknowledge and timeout to the `io` block.

---
 rtl/ps2_pkg.sv | 36 +++
 rtl/ps2_sync.sv | 37 +++
 rtl/ps2_tx.sv | 156 +++++++++++++++
 tb/tb_ps2_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        WAIT_IDLE
    } ps2_state_e;

    localparam int unsigned INHIBIT_CYCLES_DEF = 2500;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 375000;

    localparam int INH_CNT_W = 12;
    localparam int TMO_CNT_W = 19;
    localparam int BIT_CNT_W = 4;

    localparam logic [BIT_CNT_W-1:0] PAR_BIT  = 4'd9;
    localparam logic [BIT_CNT_W-1:0] STOP_BIT = 4'd10;
    localparam logic [BIT_CNT_W-1:0] ACK_BIT  = 4'd11;

    // Line level the host presents after the n-th device clock fall.
    function automatic logic frame_bit(input logic [7:0] d, input logic par,
                                       input logic [BIT_CNT_W-1:0] n);
        logic b;
        b = 1'b1;
        if (n >= 4'd1 && n <= 4'd8) begin
            b = d[3'(n - 4'd1)];
        end else if (n == PAR_BIT) begin
            b = par;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pins with a
// falling-edge strobe on the clock line.
module ps2_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic ps_clk_i,
    input  logic ps_dat_i,
    output logic clk_sync_o,
    output logic dat_sync_o,
    output logic clk_fall_o
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;

    // Reset to the idle-high bus level so release never looks like an edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps_clk_i;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps_dat_i;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign clk_sync_o = clk_sync_q;
    assign dat_sync_o = dat_sync_q;
    assign clk_fall_o = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send, clocked
// frame driven by the device, ack sampling, and a whole-transfer timeout.
//
// state     | meaning
// IDLE      | lines released, waiting for send
// INHIBIT   | clock held low; data pulled low in the final cycle (start bit)
// REQ       | clock released, start bit on data, waiting for first device fall
// XFER      | one frame bit presented per device clock fall; ack sampled at 11
// WAIT_IDLE | waiting for device to release both lines
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       ps_clk_i,
    input  logic       ps_dat_i,
    output logic       ps_clk_oe,
    output logic       ps_dat_oe,
    input  logic       send,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam logic [INH_CNT_W-1:0] INH_LAST = INH_CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_state_e           state_q, state_d;
    logic [INH_CNT_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TMO_CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]           data_q, data_d;
    logic                 par_q, par_d;
    logic                 ack_q, ack_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;

    logic clk_sync, dat_sync, clk_fall;

    ps2_sync u_sync (
        .clock      (clock),
        .reset_n    (reset_n),
        .ps_clk_i   (ps_clk_i),
        .ps_dat_i   (ps_dat_i),
        .clk_sync_o (clk_sync),
        .dat_sync_o (dat_sync),
        .clk_fall_o (clk_fall)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            inh_cnt_q <= '0;
            tmo_cnt_q <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_q     <= 1'b0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            inh_cnt_q <= inh_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        ack_d     = ack_q;
        done_d    = 1'b0;
        error_d   = error_q;

        unique case (state_q)
            IDLE: begin
                if (send) begin
                    data_d    = data;
                    par_d     = ~^data;
                    error_d   = 1'b0;
                    inh_cnt_d = '0;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_cnt_q == INH_LAST) begin
                    tmo_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            REQ, XFER, WAIT_IDLE: begin
                // Timeout wins over any edge or idle detection in the same cycle.
                if (tmo_cnt_q == TMO_LAST) begin
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if (state_q == WAIT_IDLE) begin
                        if (clk_sync && dat_sync) begin
                            done_d  = 1'b1;
                            error_d = ~ack_q;
                            state_d = IDLE;
                        end
                    end else if (clk_fall) begin
                        if (bit_cnt_q == STOP_BIT) begin
                            ack_d     = ~dat_sync;
                            bit_cnt_d = ACK_BIT;
                            state_d   = WAIT_IDLE;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            state_d   = XFER;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ps_clk_oe = 1'b0;
        ps_dat_oe = 1'b0;
        unique case (state_q)
            INHIBIT: begin
                ps_clk_oe = 1'b1;
                ps_dat_oe = (inh_cnt_q == INH_LAST);
            end
            REQ:     ps_dat_oe = 1'b1;
            XFER:    ps_dat_oe = ~frame_bit(data_q, par_q, bit_cnt_q);
            default: ps_dat_oe = 1'b0;
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: open-drain bus with a behavioural PS/2 device that clocks
// frames, records the bits it samples and optionally acknowledges.
module tb_ps2_tx;

    localparam int INH = 20;
    localparam int TMO = 4000;
    localparam int HP  = 40;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       send;
    logic [7:0] data;
    logic       ps_clk_oe, ps_dat_oe, busy, done, error;
    logic       dev_clk_low, dev_dat_low;
    logic       clk_pin, dat_pin;

    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    logic       err_at_done, busy_at_done;
    logic [1:0] oe_at_done;

    assign clk_pin = !(ps_clk_oe || dev_clk_low);
    assign dat_pin = !(ps_dat_oe || dev_dat_low);

    always #20 clock = ~clock;

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ps_clk_i  (clk_pin),
        .ps_dat_i  (dat_pin),
        .ps_clk_oe (ps_clk_oe),
        .ps_dat_oe (ps_dat_oe),
        .send      (send),
        .data      (data),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always @(negedge clock) begin
        if (done === 1'b1) begin
            done_cnt     <= done_cnt + 1;
            err_at_done  <= error;
            busy_at_done <= busy;
            oe_at_done   <= {ps_clk_oe, ps_dat_oe};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Device view of a frame: data LSB first, odd parity, stop=1.
    function automatic logic [9:0] exp_frame(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2 == 0);
        return {1'b1, p, d};
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_send(input logic [7:0] d);
        @(negedge clock);
        data = d;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int prev);
        for (int i = 0; i < 600; i++) begin
            if (done_cnt != prev) break;
            @(negedge clock);
        end
        check({tag, "_done_cnt"}, done_cnt, prev + 1);
    endtask

    task automatic dev_frame(input int n_falls, input bit ack, input int poke_at,
                             input logic [7:0] poke_val,
                             output logic [9:0] bits, output bit started);
        started = 1'b0;
        bits    = 'x;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (clk_pin && !dat_pin) begin
                started = 1'b1;
                break;
            end
        end
        if (started) begin
            wait_cyc(HP);
            for (int n = 1; n <= n_falls; n++) begin
                dev_clk_low = 1'b1;
                @(negedge clock);
                if (n == poke_at) begin
                    data = poke_val;
                    send = 1'b1;
                end
                @(negedge clock);
                send = 1'b0;
                if (n == n_falls && n < 11) begin
                    wait_cyc(10);
                    break;
                end
                wait_cyc(HP - 2);
                dev_clk_low = 1'b0;
                if (n <= 10) bits[n-1] = dat_pin;
                if (n == 11) dev_dat_low = 1'b0;
                wait_cyc(HP / 2);
                if (n == 10) dev_dat_low = ack;
                wait_cyc(HP / 2);
            end
        end
    endtask

    task automatic run_xfer(input string tag, input logic [7:0] d, input bit ack,
                            input int poke_at, input logic [7:0] poke_val);
        int         prev;
        logic [9:0] bits;
        bit         started;
        prev = done_cnt;
        do_send(d);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_err_clr"}, error, 0);
        for (int j = 1; j <= INH + 1; j++) begin
            if (j > 1) @(negedge clock);
            check($sformatf("%s_clk_oe_%0d", tag, j), ps_clk_oe, j <= INH);
            check($sformatf("%s_dat_oe_%0d", tag, j), ps_dat_oe, j >= INH);
        end
        dev_frame(11, ack, poke_at, poke_val, bits, started);
        check({tag, "_start"}, started, 1);
        wait_done(tag, prev);
        check({tag, "_bits"}, bits, exp_frame(d));
        check({tag, "_error"}, err_at_done, !ack);
        check({tag, "_busy_at_done"}, busy_at_done, 0);
        check({tag, "_oe_at_done"}, oe_at_done, 0);
    endtask

    initial begin
        int         prev;
        logic [9:0] bits;
        bit         started;
        logic [7:0] d;
        bit         a;

        reset_n     = 1'b0;
        send        = 1'b0;
        data        = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        wait_cyc(3);
        check("rst_clk_oe", ps_clk_oe, 0);
        check("rst_dat_oe", ps_dat_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        reset_n = 1'b1;
        wait_cyc(3);

        run_xfer("ed_ack", 8'hED, 1'b1, 0, 8'h00);
        run_xfer("02_ack", 8'h02, 1'b1, 0, 8'h00);

        run_xfer("nack", 8'h5A, 1'b0, 0, 8'h00);
        wait_cyc(10);
        check("nack_error_held", error, 1);

        // Device never clocks: timeout counted from the first REQ cycle.
        prev = done_cnt;
        do_send(8'hFF);
        check("tmo_err_clr", error, 0);
        wait_cyc(INH);
        check("tmo_req_clk_oe", ps_clk_oe, 0);
        check("tmo_req_dat_oe", ps_dat_oe, 1);
        wait_cyc(TMO - 1);
        check("tmo_last_dat_oe", ps_dat_oe, 1);
        check("tmo_last_done", done, 0);
        wait_cyc(1);
        check("tmo_done", done, 1);
        check("tmo_error", error, 1);
        check("tmo_busy", busy, 0);
        check("tmo_clk_oe", ps_clk_oe, 0);
        check("tmo_dat_oe", ps_dat_oe, 0);
        wait_cyc(2);
        check("tmo_done_cnt", done_cnt, prev + 1);

        // Asynchronous reset in the middle of the frame (after fall 5, bit4 of 0x0F is 0).
        prev = done_cnt;
        do_send(8'h0F);
        dev_frame(5, 1'b1, 0, 8'h00, bits, started);
        check("rst_mid_start", started, 1);
        check("rst_mid_dat_oe_pre", ps_dat_oe, 1);
        #5 reset_n = 1'b0;
        #1;
        check("rst_mid_clk_oe", ps_clk_oe, 0);
        check("rst_mid_dat_oe", ps_dat_oe, 0);
        check("rst_mid_busy", busy, 0);
        dev_clk_low = 1'b0;
        wait_cyc(5);
        reset_n = 1'b1;
        wait_cyc(50);
        check("rst_mid_no_done", done_cnt, prev);
        run_xfer("after_rst", 8'hA7, 1'b1, 0, 8'h00);

        // send while busy is dropped; only the first byte goes out.
        prev = done_cnt;
        run_xfer("busy_poke", 8'h3C, 1'b1, 3, 8'hC3);
        wait_cyc(200);
        check("busy_poke_single_done", done_cnt, prev + 1);
        check("busy_poke_idle", busy, 0);

        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            a = 1'($urandom_range(0, 1));
            run_xfer($sformatf("rnd%0d", i), d, a, 0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
